// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   uart_state_t     frame state machine encoding (IDLE, START, DATA, STOP)
//   UART_IDLE_LEVEL  line level while no frame is on the wire (mark)
//   clks_per_bit()   truncating clock-cycles-per-bit calculation
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Truncating division: any fractional remainder is a baud-rate error
    // the integrator accepts when choosing CLK_HZ and BAUD.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_framer_if
// Byte handshake and line-side status between a byte producer and the UART
// transmitter.
//   TX_DATA   producer -> framer  byte to send (DATA_BITS wide)
//   TX_VALID  producer -> framer  producer has a byte
//   TX_READY  framer -> producer  framer can accept this cycle
//   TX        framer -> pin       serial line, idle high
//   BUSY      framer -> producer  a frame is on the wire
//   DONE      framer -> producer  one-cycle pulse after a completed frame
// Modports: master = producer side, slave = framer side.
// -----------------------------------------------------------------------------
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 TX;
    logic                 BUSY;
    logic                 DONE;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  TX,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output TX,
        output BUSY,
        output DONE
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Restartable bit timer. Counts clocks 0..CLKS_PER_BIT-1 and raises bit_end
// for one cycle on the last clock of every bit period.
//   CLK      in   clock, rising edge
//   RESET    in   synchronous, active-high reset (counter to 0)
//   restart  in   reload the counter so the next cycle is clock 0 of a bit
//   bit_end  out  high on the final clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic CLK,
    input  logic RESET,
    input  logic restart,
    output logic bit_end
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default on the first line so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        // Reload at the terminal count so the counter never wraps on its own.
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
// UART transmitter: accepts one byte per valid/ready handshake and sends it
// LSB-first as start bit, DATA_BITS data bits, STOP_BITS stop bits.
//   CLK    in     clock, rising edge
//   RESET  in     synchronous, active-high reset; aborts any frame in flight
//   bus    slave  TX_DATA/TX_VALID/TX_READY handshake plus TX, BUSY, DONE
// A byte is latched on the edge where TX_VALID && TX_READY; the start bit
// appears the following cycle. TX, BUSY and DONE are registered.
// -----------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    uart_tx_framer_if.slave  bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int MAX_BITS     = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W        = $clog2(MAX_BITS + 1);

    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_framer: CLK_HZ/BAUD must give at least 2 clocks per bit");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be 5..8");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1..2");
    end

    uart_state_t           state_q,   state_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  tx_ready;
    logic                  restart;
    logic                  bit_end;

    // The baud timer restarts on accept so every frame begins with a full
    // start-bit period, independent of where the timer was while idle.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .CLK     (CLK),
        .RESET   (RESET),
        .restart (restart),
        .bit_end (bit_end)
    );

    // Ready is combinational on RESET so the producer sees it low during
    // reset and high on the very first cycle after reset is released.
    assign tx_ready = (state_q == IDLE) && !RESET;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        restart   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.TX_VALID && tx_ready) begin
                    shift_d   = bus.TX_DATA;
                    bit_cnt_d = '0;
                    tx_d      = ~UART_IDLE_LEVEL;
                    busy_d    = 1'b1;
                    restart   = 1'b1;
                    state_d   = START;
                end
            end

            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        tx_d      = UART_IDLE_LEVEL;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            // NOTE: shift_q is always loaded before use, so its reset is not
            // functionally required; clearing it keeps reset state fully known.
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.TX_READY = tx_ready;
    assign bus.TX       = tx_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
// Directed bench for uart_tx_framer at 10 clocks per bit. dut_a is 8N1,
// dut_b is 7 data bits with 2 stop bits. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

    localparam int CPB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sel;          // 0: stimulus/observation on dut_a, 1: on dut_b
    int   checks = 0;
    int   errors = 0;
    int   done_total_a = 0;
    int   done_total_b = 0;

    uart_tx_framer_if #(.DATA_BITS(8)) if_a ();
    uart_tx_framer_if #(.DATA_BITS(7)) if_b ();

    uart_tx_framer #(
        .CLK_HZ    (1000),
        .BAUD      (100),
        .DATA_BITS (8),
        .STOP_BITS (1)
    ) dut_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if_a.slave)
    );

    uart_tx_framer #(
        .CLK_HZ    (1000),
        .BAUD      (100),
        .DATA_BITS (7),
        .STOP_BITS (2)
    ) dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if_b.slave)
    );

    logic tx_o, busy_o, done_o, ready_o;
    always_comb begin
        tx_o    = sel ? if_b.TX       : if_a.TX;
        busy_o  = sel ? if_b.BUSY     : if_a.BUSY;
        done_o  = sel ? if_b.DONE     : if_a.DONE;
        ready_o = sel ? if_b.TX_READY : if_a.TX_READY;
    end

    // Count DONE pulses; sampled at the rising edge, i.e. the value held
    // during the cycle that just ended.
    always @(posedge clk) begin
        if (if_a.DONE === 1'b1) done_total_a++;
        if (if_b.DONE === 1'b1) done_total_b++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached, required earlier finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            if_b.TX_VALID = v;
            if_b.TX_DATA  = d[6:0];
        end else begin
            if_a.TX_VALID = v;
            if_a.TX_DATA  = d;
        end
    endtask

    // Expected line level k clocks after the first start-bit clock.
    function automatic logic exp_bit(input logic [7:0] b, input int nd, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= nd) return b[idx-1];
        return 1'b1;
    endfunction

    // Called 1 unit after a rising edge in an idle cycle: offers the byte and
    // returns just after the accept edge (first start-bit cycle).
    task automatic accept(input logic [7:0] b, input string tag);
        drive(1'b1, b);
        @(negedge clk);
        check($sformatf("%s ready_before_accept", tag), ready_o, 1);
        next_cycle();
    endtask

    // Checks every cycle of a whole frame. With noise set, TX_VALID is pulsed
    // and TX_DATA inverted while the frame is in progress.
    task automatic tx_frame(input logic [7:0] b, input int nd, input int ns,
                            input string tag, input bit noise);
        int len;
        len = (1 + nd + ns) * CPB;
        for (int k = 0; k < len; k++) begin
            if (noise) drive(((k % 7) == 3) && (k < 90), ~b);
            @(negedge clk);
            check($sformatf("%s tx k=%0d", tag, k), tx_o, exp_bit(b, nd, k));
            check($sformatf("%s busy k=%0d", tag, k), busy_o, 1);
            check($sformatf("%s done k=%0d", tag, k), done_o, 0);
            check($sformatf("%s ready k=%0d", tag, k), ready_o, 0);
            next_cycle();
        end
    endtask

    task automatic frame_end(input string tag);
        @(negedge clk);
        check($sformatf("%s done_pulse", tag), done_o, 1);
        check($sformatf("%s ready_after", tag), ready_o, 1);
        check($sformatf("%s busy_after", tag), busy_o, 0);
        check($sformatf("%s tx_idle", tag), tx_o, 1);
    endtask

    initial begin
        int base;

        // ---- Test 6: reset values, RESET held for 3 cycles from power-up
        rst = 1'b1;
        sel = 1'b0;
        if_a.TX_VALID = 1'b0;
        if_a.TX_DATA  = 8'h00;
        if_b.TX_VALID = 1'b0;
        if_b.TX_DATA  = 7'h00;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rst a tx c%0d", i), if_a.TX, 1);
            check($sformatf("rst a busy c%0d", i), if_a.BUSY, 0);
            check($sformatf("rst a done c%0d", i), if_a.DONE, 0);
            check($sformatf("rst a ready c%0d", i), if_a.TX_READY, 0);
            check($sformatf("rst b tx c%0d", i), if_b.TX, 1);
            check($sformatf("rst b ready c%0d", i), if_b.TX_READY, 0);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rel a ready", if_a.TX_READY, 1);
        check("rel a tx", if_a.TX, 1);
        check("rel a busy", if_a.BUSY, 0);
        check("rel a done", if_a.DONE, 0);
        check("rel b ready", if_b.TX_READY, 1);
        next_cycle();

        // ---- Test 1: single byte 0x55
        base = done_total_a;
        accept(8'h55, "t1");
        drive(1'b0, 8'hA3);
        tx_frame(8'h55, 8, 1, "t1", 1'b0);
        frame_end("t1");
        next_cycle();
        @(negedge clk);
        check("t1 done_one_cycle", done_o, 0);
        check("t1 done_count", done_total_a - base, 1);
        next_cycle();

        // ---- Test 2: 0x00 then 0xFF with TX_VALID held high
        base = done_total_a;
        accept(8'h00, "t2a");
        drive(1'b1, 8'hFF);
        tx_frame(8'h00, 8, 1, "t2a", 1'b0);
        frame_end("t2a");          // accept of 0xFF happens at the end of this cycle
        next_cycle();
        drive(1'b0, 8'h00);
        tx_frame(8'hFF, 8, 1, "t2b", 1'b0);
        frame_end("t2b");
        next_cycle();
        @(negedge clk);
        check("t2 done_count", done_total_a - base, 2);
        check("t2 idle_tx", tx_o, 1);
        next_cycle();

        // ---- Test 3: RESET during data bit 3
        base = done_total_a;
        accept(8'h3C, "t3");
        drive(1'b0, 8'h00);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            check($sformatf("t3 tx k=%0d", k), tx_o, exp_bit(8'h3C, 8, k));
            next_cycle();
        end
        rst = 1'b1;                // cycle t0+46
        @(negedge clk);
        check("t3 tx_before_reset", tx_o, exp_bit(8'h3C, 8, 45));
        check("t3 ready_in_reset", ready_o, 0);
        next_cycle();              // cycle t0+47
        rst = 1'b0;
        @(negedge clk);
        check("t3 tx_after_reset", tx_o, 1);
        check("t3 busy_after_reset", busy_o, 0);
        check("t3 done_after_reset", done_o, 0);
        check("t3 ready_after_reset", ready_o, 1);
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("t3 idle tx k=%0d", k), tx_o, 1);
            check($sformatf("t3 idle done k=%0d", k), done_o, 0);
        end
        check("t3 no_done", done_total_a - base, 0);
        next_cycle();
        accept(8'hA5, "t3r");
        drive(1'b0, 8'h00);
        tx_frame(8'hA5, 8, 1, "t3r", 1'b0);
        frame_end("t3r");
        next_cycle();

        // ---- Test 4: TX_DATA/TX_VALID activity while BUSY
        base = done_total_a;
        accept(8'h96, "t4");
        tx_frame(8'h96, 8, 1, "t4", 1'b1);
        frame_end("t4");
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("t4 no_extra tx k=%0d", k), tx_o, 1);
            check($sformatf("t4 no_extra busy k=%0d", k), busy_o, 0);
        end
        check("t4 done_count", done_total_a - base, 1);
        next_cycle();

        // ---- Test 5: 7 data bits, 2 stop bits, 0x41
        sel = 1'b1;
        base = done_total_b;
        accept(8'h41, "t5");
        drive(1'b0, 8'h00);
        tx_frame(8'h41, 7, 2, "t5", 1'b0);
        frame_end("t5");
        next_cycle();
        @(negedge clk);
        check("t5 done_count", done_total_b - base, 1);
        check("t5 done_one_cycle", done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
